// File: rtl/keycode_conditioner.sv
// keycode_conditioner: filters torn/transient NIOS keyboard reports, resolves
// left/right by last-pressed priority and presents frame-aligned game controls.
module keycode_conditioner #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter logic [7:0]  KEY_LEFT      = 8'h04,
    parameter logic [7:0]  KEY_RIGHT     = 8'h07,
    parameter logic [7:0]  KEY_START     = 8'h2C,
    parameter logic [7:0]  KEY_PAUSE     = 8'h13
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] keycode_raw,
    input  logic        frame_clk,
    output logic [7:0]  keycode,
    output logic        start_pulse,
    output logic        paused
);

    localparam int unsigned    CW      = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_t;

    logic [31:0]   raw_q;
    logic [31:0]   acc;
    logic [CW-1:0] stab_cnt;
    logic [1:0]    fe;
    dir_t          last_dir;
    dir_t          dir_nxt;
    logic          prev_s;
    logic          prev_p;

    logic          sample_match;
    logic          acc_load;
    logic          acc_change;
    logic          frame_evt;
    logic          held_l, held_r, held_s, held_p;
    logic          new_l, new_r;
    logic [7:0]    slot_code;
    logic [7:0]    kc_sel;

    function automatic logic has_key(input logic [31:0] rpt, input logic [7:0] key);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            hit |= (rpt[8*i +: 8] == key);
        end
        return hit;
    endfunction

    assign sample_match = (keycode_raw == raw_q);
    assign acc_load     = sample_match && (stab_cnt == CNT_MAX);
    assign acc_change   = acc_load && (raw_q != acc);
    assign frame_evt    = (fe == 2'b01);

    assign held_l = has_key(acc, KEY_LEFT);
    assign held_r = has_key(acc, KEY_RIGHT);
    assign held_s = has_key(acc, KEY_START);
    assign held_p = has_key(acc, KEY_PAUSE);
    assign new_l  = has_key(raw_q, KEY_LEFT);
    assign new_r  = has_key(raw_q, KEY_RIGHT);

    // A fresh right press is tested first so a simultaneous L+R press resolves to RIGHT.
    always_comb begin
        dir_nxt = last_dir;
        if (acc_change) begin
            if (new_r && !held_r)      dir_nxt = DIR_RIGHT;
            else if (new_l && !held_l) dir_nxt = DIR_LEFT;
            else if (!new_l && !new_r) dir_nxt = DIR_NONE;
            else if (!new_l)           dir_nxt = DIR_RIGHT;
            else if (!new_r)           dir_nxt = DIR_LEFT;
        end
    end

    always_comb begin
        slot_code = 8'h00;
        for (int unsigned i = 0; i < 4; i++) begin
            if (slot_code == 8'h00 && acc[8*i +: 8] != 8'h00 &&
                acc[8*i +: 8] != KEY_START && acc[8*i +: 8] != KEY_PAUSE) begin
                slot_code = acc[8*i +: 8];
            end
        end
    end

    always_comb begin
        case (last_dir)
            DIR_LEFT:  kc_sel = KEY_LEFT;
            DIR_RIGHT: kc_sel = KEY_RIGHT;
            default:   kc_sel = slot_code;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            raw_q    <= '0;
            stab_cnt <= '0;
            acc      <= '0;
            last_dir <= DIR_NONE;
            fe       <= '0;
        end else begin
            raw_q    <= keycode_raw;
            fe       <= {fe[0], frame_clk};
            last_dir <= dir_nxt;
            if (!sample_match)
                stab_cnt <= '0;
            else if (stab_cnt != CNT_MAX)
                stab_cnt <= stab_cnt + 1'b1;
            if (acc_load)
                acc <= raw_q;
        end
    end

    // Frame outputs sample acc/last_dir as registered; a same-cycle acc update lands next frame.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            keycode     <= '0;
            start_pulse <= 1'b0;
            paused      <= 1'b0;
            prev_s      <= 1'b0;
            prev_p      <= 1'b0;
        end else begin
            start_pulse <= 1'b0;
            if (frame_evt) begin
                keycode     <= kc_sel;
                start_pulse <= held_s && !prev_s;
                if (held_p && !prev_p)
                    paused <= ~paused;
                prev_s <= held_s;
                prev_p <= held_p;
            end
        end
    end

endmodule
